// File: rtl/mem_lsu_queue.sv
// MEM-stage load/store unit: issues sram_like requests, keeps up to DEPTH ops in flight in program
// order, extends load data, flags misaligned accesses and retires through a valid/ready port.
module mem_lsu_queue #(
    parameter int          DEPTH     = 4,
    parameter int          TAG_W     = 5,
    parameter logic [31:0] ADDR_MASK = 32'h1fffffff
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_load,
    input  logic             in_store,
    input  logic [1:0]       in_size,
    input  logic             in_unsigned,
    input  logic [31:0]      in_addr,
    input  logic [31:0]      in_wdata,
    input  logic             in_wen,
    input  logic [TAG_W-1:0] in_wdest,
    input  logic [31:0]      in_pc,
    input  logic             cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic             out_wen,
    output logic [TAG_W-1:0] out_wdest,
    output logic [31:0]      out_pc,
    output logic             out_adel,
    output logic             out_ades,
    output logic [31:0]      out_badvaddr,
    output logic             data_req,
    output logic             data_wr,
    output logic [1:0]       data_size,
    output logic [31:0]      data_addr,
    output logic [31:0]      data_wdata,
    input  logic [31:0]      data_rdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = PW + 4;

    // Handshakes: an op moves on in_valid & in_ready, a result on out_valid & out_ready,
    // a bus request on data_req & data_addr_ok; data_data_ok returns responses in request order.

    logic [31:0]      e_result [DEPTH];
    logic [31:0]      e_pc     [DEPTH];
    logic [31:0]      e_bad    [DEPTH];
    logic [TAG_W-1:0] e_wdest  [DEPTH];
    logic [1:0]       e_size   [DEPTH];
    logic [DEPTH-1:0] e_done, e_wen, e_adel, e_ades, e_load, e_uns;

    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    // Indices of issued-but-unanswered memops, oldest first.
    logic [PW-1:0] rq [DEPTH];
    logic [PW-1:0] rq_rp, rq_wp;
    logic [CW-1:0] owed;
    logic [DW-1:0] discard;

    logic [1:0]    size_eff;
    logic          mis, memop, full, push, pop, drop, resp;
    logic [PW-1:0] rslot;
    logic [1:0]    rlo;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [31:0]   load_val;

    assign size_eff = (in_size == 2'd3) ? 2'd2 : in_size;
    assign mis      = ((size_eff == 2'd1) & in_addr[0]) |
                      ((size_eff == 2'd2) & (in_addr[1:0] != 2'b00));
    assign memop    = (in_load | in_store) & ~mis;
    assign full     = (count == CW'(DEPTH));

    assign data_req  = in_valid & memop & ~full & ~cancel;
    assign in_ready  = ~full & ~cancel & (~memop | data_addr_ok);
    assign data_wr   = in_store;
    assign data_size = size_eff;
    assign data_addr = in_addr & ADDR_MASK;

    always_comb begin
        data_wdata = in_wdata;
        case (size_eff)
            2'd0:    data_wdata = {4{in_wdata[7:0]}};
            2'd1:    data_wdata = {2{in_wdata[15:0]}};
            default: data_wdata = in_wdata;
        endcase
    end

    assign push      = in_valid & in_ready;
    assign out_valid = (count != '0) & e_done[head];
    assign pop       = out_valid & out_ready;
    assign drop      = data_data_ok & (discard != '0);
    assign resp      = data_data_ok & (discard == '0) & (owed != '0);

    assign out_result   = e_result[head];
    assign out_wen      = e_wen[head];
    assign out_wdest    = e_wdest[head];
    assign out_pc       = e_pc[head];
    assign out_adel     = e_adel[head];
    assign out_ades     = e_ades[head];
    assign out_badvaddr = e_bad[head];

    // Lane extraction uses the low address bits of the unmasked virtual address.
    always_comb begin
        rslot = rq[rq_rp];
        rlo   = e_bad[rslot][1:0];
        rbyte = data_rdata[{rlo, 3'b000} +: 8];
        rhalf = data_rdata[{rlo[1], 4'b0000} +: 16];
        load_val = data_rdata;
        case (e_size[rslot])
            2'd0:    load_val = e_uns[rslot] ? {24'd0, rbyte} : {{24{rbyte[7]}}, rbyte};
            2'd1:    load_val = e_uns[rslot] ? {16'd0, rhalf} : {{16{rhalf[15]}}, rhalf};
            default: load_val = data_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rq_rp   <= '0;
            rq_wp   <= '0;
            owed    <= '0;
            discard <= '0;
            e_done  <= '0;
            e_wen   <= '0;
            e_adel  <= '0;
            e_ades  <= '0;
            e_load  <= '0;
            e_uns   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_result[i] <= '0;
                e_pc[i]     <= '0;
                e_bad[i]    <= '0;
                e_wdest[i]  <= '0;
                e_size[i]   <= '0;
                rq[i]       <= '0;
            end
        end else if (cancel) begin
            // Everything still owed by the bus becomes a response to swallow.
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rq_rp   <= '0;
            rq_wp   <= '0;
            owed    <= '0;
            discard <= discard + DW'(owed) - DW'(drop | resp);
        end else begin
            if (push) begin
                e_result[tail] <= in_addr;
                e_pc[tail]     <= in_pc;
                e_bad[tail]    <= in_addr;
                e_wdest[tail]  <= in_wdest;
                e_size[tail]   <= size_eff;
                e_done[tail]   <= ~memop;
                e_wen[tail]    <= in_wen & ~mis;
                e_adel[tail]   <= mis & in_load;
                e_ades[tail]   <= mis & in_store;
                e_load[tail]   <= in_load;
                e_uns[tail]    <= in_unsigned;
                tail           <= tail + PW'(1);
                if (memop) begin
                    rq[rq_wp] <= tail;
                    rq_wp     <= rq_wp + PW'(1);
                end
            end
            if (resp) begin
                e_done[rslot] <= 1'b1;
                if (e_load[rslot])
                    e_result[rslot] <= load_val;
                rq_rp <= rq_rp + PW'(1);
            end
            if (drop)
                discard <= discard - DW'(1);
            if (pop)
                head <= head + PW'(1);
            count <= count + CW'(push) - CW'(pop);
            owed  <= owed + CW'(push & memop) - CW'(resp);
        end
    end

endmodule

// File: tb/tb_mem_lsu_queue.sv
// Directed bench for mem_lsu_queue: a queue-of-ops model checked every cycle, plus hand-computed
// literal expectations for the documented scenarios.
module tb_mem_lsu_queue;

    localparam int          DEPTH = 4;
    localparam int          TAG_W = 5;
    localparam logic [31:0] MASK  = 32'h1fffffff;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0, in_ready;
    logic             in_load = 1'b0, in_store = 1'b0, in_unsigned = 1'b0, in_wen = 1'b0;
    logic [1:0]       in_size = 2'd0;
    logic [31:0]      in_addr = '0, in_wdata = '0, in_pc = '0;
    logic [TAG_W-1:0] in_wdest = '0;
    logic             cancel = 1'b0;
    logic             out_valid, out_ready = 1'b1;
    logic [31:0]      out_result, out_pc, out_badvaddr;
    logic             out_wen, out_adel, out_ades;
    logic [TAG_W-1:0] out_wdest;
    logic             data_req, data_wr;
    logic [1:0]       data_size;
    logic [31:0]      data_addr, data_wdata;
    logic [31:0]      data_rdata = '0;
    logic             data_addr_ok = 1'b0, data_data_ok = 1'b0;

    int errors = 0;
    int checks = 0;

    mem_lsu_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADDR_MASK(MASK)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_load(in_load), .in_store(in_store),
        .in_size(in_size), .in_unsigned(in_unsigned), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_wen(in_wen), .in_wdest(in_wdest), .in_pc(in_pc), .cancel(cancel),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_wen(out_wen), .out_wdest(out_wdest), .out_pc(out_pc), .out_adel(out_adel),
        .out_ades(out_ades), .out_badvaddr(out_badvaddr),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0]      result;
        logic [31:0]      pc;
        logic [31:0]      bad;
        logic [TAG_W-1:0] wdest;
        logic             wen, adel, ades, done, load, uns;
        logic [1:0]       size;
    } ent_t;

    ent_t mq[$];
    int   m_disc = 0;
    logic prev_reset = 1'b0;

    function automatic logic [31:0] ext_load(input logic [31:0] rd, input logic [1:0] lo,
                                             input logic [1:0] sz, input logic uns);
        logic [31:0] sh;
        if (sz == 2'd0) begin
            sh = rd >> (int'(lo) * 8);
            return uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (sz == 2'd1) begin
            sh = rd >> (int'(lo[1]) * 16);
            return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end
        return rd;
    endfunction

    function automatic logic [31:0] lanes(input logic [31:0] wd, input logic [1:0] sz);
        if (sz == 2'd0) return {wd[7:0], wd[7:0], wd[7:0], wd[7:0]};
        if (sz == 2'd1) return {wd[15:0], wd[15:0]};
        return wd;
    endfunction

    always @(negedge clk) begin
        logic [1:0] sz;
        logic       mis, memop, full, e_req, e_rdy, e_ov, found;
        int         pend;
        ent_t       e;
        sz    = (in_size == 2'd3) ? 2'd2 : in_size;
        mis   = (sz == 2'd1 && in_addr[0]) || (sz == 2'd2 && in_addr[1:0] != 2'b00);
        memop = (in_load || in_store) && !mis;
        full  = (mq.size() == DEPTH);
        e_req = in_valid && memop && !full && !cancel;
        e_rdy = !full && !cancel && (!memop || data_addr_ok);
        e_ov  = (mq.size() > 0) && mq[0].done;

        if (prev_reset) begin
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_result", out_result, 0);
            chk("rst_out_pc", out_pc, 0);
            chk("rst_out_bad", out_badvaddr, 0);
            chk("rst_out_flags", {27'd0, out_wen, out_adel, out_ades, 2'b00}, 0);
            chk("rst_out_wdest", 32'(out_wdest), 0);
        end
        chk("m_in_ready", 32'(in_ready), 32'(e_rdy));
        chk("m_data_req", 32'(data_req), 32'(e_req));
        if (e_req) begin
            chk("m_data_wr", 32'(data_wr), 32'(in_store));
            chk("m_data_size", 32'(data_size), 32'(sz));
            chk("m_data_addr", data_addr, in_addr & MASK);
            chk("m_data_wdata", data_wdata, lanes(in_wdata, sz));
        end
        chk("m_out_valid", 32'(out_valid), 32'(e_ov));
        if (e_ov) begin
            chk("m_out_result", out_result, mq[0].result);
            chk("m_out_wen", 32'(out_wen), 32'(mq[0].wen));
            chk("m_out_wdest", 32'(out_wdest), 32'(mq[0].wdest));
            chk("m_out_pc", out_pc, mq[0].pc);
            chk("m_out_adel", 32'(out_adel), 32'(mq[0].adel));
            chk("m_out_ades", 32'(out_ades), 32'(mq[0].ades));
            chk("m_out_bad", out_badvaddr, mq[0].bad);
        end

        if (reset) begin
            mq.delete();
            m_disc = 0;
        end else begin
            if (data_data_ok) begin
                if (m_disc > 0) m_disc--;
                else begin
                    found = 1'b0;
                    for (int i = 0; i < mq.size(); i++) begin
                        if (!found && !mq[i].done) begin
                            found = 1'b1;
                            e = mq[i];
                            e.done = 1'b1;
                            if (e.load) e.result = ext_load(data_rdata, e.bad[1:0], e.size, e.uns);
                            mq[i] = e;
                        end
                    end
                end
            end
            if (cancel) begin
                pend = 0;
                foreach (mq[i]) if (!mq[i].done) pend++;
                m_disc += pend;
                mq.delete();
            end else begin
                if (e_ov && out_ready) void'(mq.pop_front());
                if (in_valid && e_rdy) begin
                    e.result = in_addr;
                    e.pc     = in_pc;
                    e.bad    = in_addr;
                    e.wdest  = in_wdest;
                    e.adel   = mis && in_load;
                    e.ades   = mis && in_store;
                    e.wen    = in_wen && !e.adel && !e.ades;
                    e.done   = !memop;
                    e.load   = in_load;
                    e.uns    = in_unsigned;
                    e.size   = sz;
                    mq.push_back(e);
                end
            end
        end
        prev_reset = reset;
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input logic ld, input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd, input logic wen,
                      input logic [TAG_W-1:0] dest, input logic [31:0] pc);
        in_valid = 1'b1; in_load = ld; in_store = st; in_size = sz; in_unsigned = uns;
        in_addr = addr; in_wdata = wd; in_wen = wen; in_wdest = dest; in_pc = pc;
    endtask

    task automatic idle();
        in_valid = 1'b0; in_load = 1'b0; in_store = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        step();

        // 1: aligned lw, response 2 cycles after addr_ok
        op(1, 0, 2'd2, 0, 32'h80001000, 0, 1, 5'd3, 32'h100); data_addr_ok = 1;
        @(negedge clk);
        chk("t1_req", 32'(data_req), 1);
        chk("t1_addr", data_addr, 32'h00001000);
        chk("t1_ready", 32'(in_ready), 1);
        step(); idle(); data_addr_ok = 0;
        step();
        data_data_ok = 1; data_rdata = 32'h800000F0;
        @(negedge clk); chk("t1_ov_early", 32'(out_valid), 0);
        step(); data_data_ok = 0;
        @(negedge clk);
        chk("t1_ov", 32'(out_valid), 1);
        chk("t1_result", out_result, 32'h800000F0);
        chk("t1_wdest", 32'(out_wdest), 3);
        step();

        // 2: lb / lbu lane 3, then sh with lane replication
        op(1, 0, 2'd0, 0, 32'h80001003, 0, 1, 5'd4, 32'h104); data_addr_ok = 1; step();
        op(1, 0, 2'd0, 1, 32'h80001003, 0, 1, 5'd5, 32'h108); step();
        idle(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h80FFFF00; step();
        @(negedge clk); chk("t2_lb", out_result, 32'hFFFFFF80);
        step(); data_data_ok = 0;
        @(negedge clk); chk("t2_lbu", out_result, 32'h00000080);
        step();
        op(0, 1, 2'd1, 0, 32'h00000002, 32'h00001234, 0, 5'd0, 32'h10C);
        @(negedge clk);
        chk("t2_sh_req", 32'(data_req), 1);
        chk("t2_sh_wdata", data_wdata, 32'h12341234);
        chk("t2_sh_size", 32'(data_size), 1);
        chk("t2_sh_wr", 32'(data_wr), 1);
        chk("t2_sh_wait", 32'(in_ready), 0);
        step(); data_addr_ok = 1; step();
        idle(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hFFFFFFFF; step();
        data_data_ok = 0;
        @(negedge clk);
        chk("t2_sh_result", out_result, 32'h00000002);
        chk("t2_sh_wen", 32'(out_wen), 0);
        step();

        // 3: misaligned lw / sw never reach the bus; ALU op passes through
        op(1, 0, 2'd2, 0, 32'h80001002, 0, 1, 5'd6, 32'h110); data_addr_ok = 1;
        @(negedge clk); chk("t3_noreq", 32'(data_req), 0);
        step();
        op(0, 1, 2'd2, 0, 32'h80001001, 32'h55, 0, 5'd0, 32'h114); data_addr_ok = 0;
        @(negedge clk);
        chk("t3_adel", 32'(out_adel), 1);
        chk("t3_wen", 32'(out_wen), 0);
        chk("t3_bad", out_badvaddr, 32'h80001002);
        step();
        op(0, 0, 2'd2, 0, 32'h12345678, 0, 1, 5'd7, 32'h118);
        @(negedge clk); chk("t3_ades", 32'(out_ades), 1);
        step(); idle();
        @(negedge clk);
        chk("t3_alu", out_result, 32'h12345678);
        chk("t3_alu_wen", 32'(out_wen), 1);
        step();

        // 4: fill DEPTH entries, 5th refused even while the head pops
        for (int i = 0; i < DEPTH; i++) begin
            op(1, 0, (i == 2) ? 2'd3 : 2'd2, 0, 32'h80002000 + 32'(4 * i), 0, 1,
               TAG_W'(8 + i), 32'h200 + 32'(4 * i));
            data_addr_ok = 1;
            @(negedge clk);
            if (i == 2) chk("t4_size3", 32'(data_size), 2);
            step();
        end
        op(1, 0, 2'd2, 0, 32'h80002010, 0, 1, 5'd12, 32'h210);
        data_data_ok = 1; data_rdata = 32'hA0000000;
        @(negedge clk);
        chk("t4_full_ready", 32'(in_ready), 0);
        chk("t4_full_req", 32'(data_req), 0);
        step(); data_rdata = 32'hA0000001;
        @(negedge clk);
        chk("t4_pop_full_ready", 32'(in_ready), 0);
        chk("t4_head", out_result, 32'hA0000000);
        step(); data_rdata = 32'hA0000002;
        @(negedge clk); chk("t4_accept5", 32'(in_ready), 1);
        step(); idle(); data_addr_ok = 0; data_rdata = 32'hA0000003;
        step(); data_rdata = 32'hA0000004;
        step(); data_data_ok = 0;
        repeat (4) step();
        @(negedge clk); chk("t4_empty", 32'(out_valid), 0);
        step();

        // 5: cancel with 2 outstanding; their responses are dropped
        op(1, 0, 2'd2, 0, 32'h80003000, 0, 1, 5'd1, 32'h300); data_addr_ok = 1; step();
        op(1, 0, 2'd2, 0, 32'h80003004, 0, 1, 5'd2, 32'h304); step();
        op(0, 0, 2'd2, 0, 32'h00000077, 0, 1, 5'd9, 32'h308); data_addr_ok = 0; cancel = 1;
        @(negedge clk); chk("t5_cancel_ready", 32'(in_ready), 0);
        step(); idle(); cancel = 0;
        @(negedge clk); chk("t5_flushed", 32'(out_valid), 0);
        op(1, 0, 2'd2, 0, 32'h80003008, 0, 1, 5'd10, 32'h30C); data_addr_ok = 1; step();
        idle(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD0001; step();
        data_rdata = 32'hDEAD0002; step();
        data_rdata = 32'h5555AAAA;
        @(negedge clk); chk("t5_dropped", 32'(out_valid), 0);
        step(); data_data_ok = 0;
        @(negedge clk);
        chk("t5_own_data", out_result, 32'h5555AAAA);
        chk("t5_own_pc", out_pc, 32'h30C);
        step();
        data_data_ok = 1; data_rdata = 32'h00000BAD; step();
        data_data_ok = 0;
        @(negedge clk); chk("t5_stray", 32'(out_valid), 0);
        op(1, 0, 2'd1, 0, 32'h80003012, 0, 1, 5'd11, 32'h310); data_addr_ok = 1; step();
        idle(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h8001F00D; step();
        data_data_ok = 0;
        @(negedge clk); chk("t5_lh_hi", out_result, 32'hFFFF8001);
        step();

        // 6: WB stalls while responses arrive, then reset mid-burst
        out_ready = 0;
        for (int i = 0; i < DEPTH; i++) begin
            op(1, 0, 2'd2, 0, 32'h80004000 + 32'(4 * i), 0, 1, TAG_W'(16 + i), 32'h400 + 32'(4 * i));
            data_addr_ok = 1;
            step();
        end
        idle(); data_addr_ok = 0; data_data_ok = 1;
        for (int i = 0; i < DEPTH; i++) begin
            data_rdata = 32'hC0000000 + 32'(i);
            step();
        end
        data_data_ok = 0;
        repeat (3) step();
        @(negedge clk); chk("t6_held", out_result, 32'hC0000000);
        step(); out_ready = 1;
        repeat (DEPTH + 1) step();
        out_ready = 0;
        op(1, 0, 2'd2, 0, 32'h80005000, 0, 1, 5'd20, 32'h500); data_addr_ok = 1; step();
        op(1, 0, 2'd2, 0, 32'h80005004, 0, 1, 5'd21, 32'h504); data_data_ok = 1;
        data_rdata = 32'h12345678; step();
        idle(); data_addr_ok = 0; data_data_ok = 0; reset = 1;
        step(); step(); reset = 0;
        @(negedge clk);
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_result", out_result, 0);
        step();
        out_ready = 1;
        op(1, 0, 2'd2, 0, 32'h80006000, 0, 1, 5'd22, 32'h600); data_addr_ok = 1; step();
        idle(); data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0F0F0F0F; step();
        data_data_ok = 0;
        @(negedge clk); chk("t6_after_rst", out_result, 32'h0F0F0F0F);
        repeat (2) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
